// File: rtl/freq_period_counter.sv
// freq_period_counter: measures an asynchronous signal either as edges per gate
// window (frequency mode) or as reference ticks per signal period (period mode).
// Build option: define MEAS_TIMEOUT_EN to abort period measurements after
// TO_EDGES gate rising edges without a completing signal edge.
module freq_period_counter #(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned TO_EDGES = 4
) (
   input  logic             CLK_50,
   input  logic             RST,
   input  logic             sig_in,
   input  logic             gate_in,
   input  logic             ref_in,
   input  logic             measure_mode,
   input  logic             start,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             busy,
   output logic             ovf,
   output logic             timeout
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS, ST_DONE} state_e;

   localparam int unsigned TO_W = 8;

   if (TO_EDGES < 2 || TO_EDGES > 255) begin : g_to_range_chk
      $error("freq_period_counter: TO_EDGES must lie in 2..255");
   end

   logic [2:0]       sig_sync_q, gate_sync_q, ref_sync_q;
   logic             sig_rise, gate_rise, gate_fall, ref_rise;
   state_e           state_q, state_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_flag_q, ovf_flag_d;
   logic             inc_en;
   logic             timeout_hit;
   logic [CNT_W-1:0] count_d;
   logic             valid_d, busy_d, ovf_d, timeout_d;
`ifdef MEAS_TIMEOUT_EN
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
`endif

   // Two-flop synchronisers plus a history flop for edge detection
   always_ff @(posedge CLK_50 or posedge RST) begin
      if (RST) begin
         sig_sync_q  <= '0;
         gate_sync_q <= '0;
         ref_sync_q  <= '0;
      end else begin
         sig_sync_q  <= {sig_sync_q[1:0], sig_in};
         gate_sync_q <= {gate_sync_q[1:0], gate_in};
         ref_sync_q  <= {ref_sync_q[1:0], ref_in};
      end
   end

   assign sig_rise  = sig_sync_q[1] & ~sig_sync_q[2];
   assign gate_rise = gate_sync_q[1] & ~gate_sync_q[2];
   assign gate_fall = ~gate_sync_q[1] & gate_sync_q[2];
   assign ref_rise  = ref_sync_q[1] & ~ref_sync_q[2];

   // Next-state, counter and result logic; results are captured on entry to DONE
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      ovf_flag_d  = ovf_flag_q;
      inc_en      = 1'b0;
      timeout_hit = 1'b0;
      count_d     = count;
      valid_d     = 1'b0;
      ovf_d       = ovf;
      timeout_d   = timeout;
`ifdef MEAS_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d     = measure_mode;
               cnt_d      = '0;
               ovf_flag_d = 1'b0;
`ifdef MEAS_TIMEOUT_EN
               to_cnt_d   = '0;
`endif
               state_d    = ST_ARM;
            end
         end
         ST_ARM: begin
            if (!mode_q) begin
               if (gate_rise) begin
                  state_d = ST_MEAS;
                  if (sig_rise) cnt_d = CNT_W'(1);
               end
            end else if (sig_rise) begin
               state_d = ST_MEAS;
            end
         end
         ST_MEAS: begin
            if (!mode_q) begin
               if (gate_fall)     state_d = ST_DONE;
               else if (sig_rise) inc_en  = 1'b1;
            end else begin
               if (sig_rise)      state_d = ST_DONE;
               else if (ref_rise) inc_en  = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Saturating increment: hold at all-ones and raise the sticky flag
      if (inc_en) begin
         if (cnt_q == '1) ovf_flag_d = 1'b1;
         else             cnt_d      = cnt_q + CNT_W'(1);
      end

`ifdef MEAS_TIMEOUT_EN
      // Period mode gives up after TO_EDGES gate rises
      if (mode_q && gate_rise && (state_q == ST_ARM || state_q == ST_MEAS)) begin
         if (to_cnt_q == TO_W'(TO_EDGES - 1)) begin
            timeout_hit = 1'b1;
            state_d     = ST_DONE;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end
`endif

      if (state_d == ST_DONE) begin
         valid_d   = 1'b1;
         count_d   = timeout_hit ? '1 : cnt_q;
         ovf_d     = timeout_hit ? 1'b0 : ovf_flag_q;
         timeout_d = timeout_hit;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and measurement registers
   always_ff @(posedge CLK_50 or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         mode_q     <= 1'b0;
         cnt_q      <= '0;
         ovf_flag_q <= 1'b0;
`ifdef MEAS_TIMEOUT_EN
         to_cnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         ovf_flag_q <= ovf_flag_d;
`ifdef MEAS_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
`endif
      end
   end

   // Registered outputs
   always_ff @(posedge CLK_50 or posedge RST) begin
      if (RST) begin
         count   <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         ovf     <= 1'b0;
         timeout <= 1'b0;
      end else begin
         count   <= count_d;
         valid   <= valid_d;
         busy    <= busy_d;
         ovf     <= ovf_d;
         timeout <= timeout_d;
      end
   end

endmodule

// File: tb/tb_freq_period_counter.sv
// Bench for freq_period_counter: directed and random waveforms, expectations
// computed by counting edges in the driven per-cycle waveforms.
module tb_freq_period_counter;

   localparam int unsigned W    = 8;
   localparam int unsigned TO   = 3;
   localparam int          LMAX = 6000;
   localparam int          SAT  = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst, sig_in, gate_in, ref_in, measure_mode, start;
   logic [W-1:0] count;
   logic         valid, busy, ovf, timeout;

   bit sig_a  [LMAX];
   bit gate_a [LMAX];
   bit ref_a  [LMAX];

   int checks = 0;
   int errors = 0;
   int e_cnt, e_vidx, third;
   bit e_ovf;

   freq_period_counter #(.CNT_W(W), .TO_EDGES(TO)) dut (
      .CLK_50       (clk),
      .RST          (rst),
      .sig_in       (sig_in),
      .gate_in      (gate_in),
      .ref_in       (ref_in),
      .measure_mode (measure_mode),
      .start        (start),
      .count        (count),
      .valid        (valid),
      .busy         (busy),
      .ovf          (ovf),
      .timeout      (timeout)
   );

   always #10 clk = ~clk;

   initial begin
      #(4_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit get(input int w, input int t);
      if (t < 0 || t >= LMAX) return 1'b0;
      case (w)
         0:       return sig_a[t];
         1:       return gate_a[t];
         default: return ref_a[t];
      endcase
   endfunction

   function automatic void put(input int w, input int t, input bit v);
      if (t < 0 || t >= LMAX) return;
      case (w)
         0:       sig_a[t]  = v;
         1:       gate_a[t] = v;
         default: ref_a[t]  = v;
      endcase
   endfunction

   function automatic void clr();
      for (int t = 0; t < LMAX; t++) begin
         sig_a[t] = 1'b0; gate_a[t] = 1'b0; ref_a[t] = 1'b0;
      end
   endfunction

   // Random square wave starting low, each level held 1..4 cycles
   function automatic void rand_fill(input int w, input int lo, input int hi);
      bit lvl = 1'b0;
      int t   = lo;
      while (t < hi) begin
         int hold = int'($urandom_range(1, 4));
         for (int k = 0; k < hold && t < hi; k++) begin
            put(w, t, lvl);
            t++;
         end
         lvl = ~lvl;
      end
   endfunction

   function automatic int rises(input int w, input int lo, input int hi);
      int n = 0;
      for (int t = lo; t < hi; t++)
         if (get(w, t) && !get(w, t - 1)) n++;
      return n;
   endfunction

   function automatic int first_rise(input int w, input int from);
      for (int t = from; t < LMAX; t++)
         if (get(w, t) && !get(w, t - 1)) return t;
      return -1;
   endfunction

   function automatic int first_fall(input int w, input int from);
      for (int t = from; t < LMAX; t++)
         if (!get(w, t) && get(w, t - 1)) return t;
      return -1;
   endfunction

   // Frequency: sig rises inside [gate rise, gate fall); result 3 cycles after gate fall
   task automatic model_freq(output int cnt, output bit o, output int vidx);
      int g0 = first_rise(1, 0);
      int g1 = first_fall(1, g0 + 1);
      int n  = rises(0, g0, g1);
      cnt  = (n > SAT) ? SAT : n;
      o    = (n > SAT);
      vidx = g1 + 3;
   endtask

   // Period: ref rises strictly between two consecutive sig rises
   task automatic model_period(output int cnt, output bit o, output int vidx);
      int s1 = first_rise(0, 0);
      int s2 = first_rise(0, s1 + 1);
      int n  = rises(2, s1 + 1, s2);
      cnt  = (n > SAT) ? SAT : n;
      o    = (n > SAT);
      vidx = s2 + 3;
   endtask

   task automatic idle_low(input int n);
      start = 1'b0; sig_in = 1'b0; gate_in = 1'b0; ref_in = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One measurement: start, replay the waveform tables, check the single result
   task automatic run_meas(input bit mode, input int exp_cnt, input bit exp_ovf,
                           input bit exp_to, input int vidx, input string tag);
      int vcount = 0;
      int seen   = -1;
      int len    = vidx + 3;
      @(posedge clk); #1;
      start = 1'b1; measure_mode = mode;
      for (int c = 0; c < len; c++) begin
         @(posedge clk); #1;
         start        = (c == 3);
         measure_mode = ~mode;
         sig_in  = sig_a[c];
         gate_in = gate_a[c];
         ref_in  = ref_a[c];
         @(negedge clk);
         if (c == 0) chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
         if (valid) begin
            vcount++;
            if (seen < 0) begin
               seen = c;
               chk({tag, "_count"},   32'(count),   32'(exp_cnt));
               chk({tag, "_ovf"},     32'(ovf),     32'(exp_ovf));
               chk({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
               chk({tag, "_busy_done"}, 32'(busy),  32'd1);
            end
         end
      end
      chk({tag, "_valid_cycle"}, 32'(seen),   32'(vidx));
      chk({tag, "_valid_width"}, 32'(vcount), 32'd1);
      chk({tag, "_busy_fall"},   32'(busy),   32'd0);
      idle_low(4);
   endtask

   initial begin
      rst = 1'b0; sig_in = 1'b0; gate_in = 1'b0; ref_in = 1'b0;
      measure_mode = 1'b0; start = 1'b0;
      #2 rst = 1'b1;
      #20;
      chk("rst_count",   32'(count),   32'd0);
      chk("rst_valid",   32'(valid),   32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_ovf",     32'(ovf),     32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      @(negedge clk); rst = 1'b0;
      idle_low(4);

      // Directed frequency: 1000-cycle window, sig period 10
      clr();
      for (int t = 5; t < 1005; t++) gate_a[t] = 1'b1;
      for (int t = 8; t < 1010; t++) sig_a[t] = ((t - 8) % 10) < 5;
      model_freq(e_cnt, e_ovf, e_vidx);
      run_meas(1'b0, e_cnt, e_ovf, 1'b0, e_vidx, "freq100");

      // Abort mid-measurement: outputs clear at once, then idle
      clr();
      for (int t = 5; t < LMAX; t++) gate_a[t] = 1'b1;
      rand_fill(0, 0, 100);
      @(posedge clk); #1;
      start = 1'b1; measure_mode = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         sig_in = sig_a[c]; gate_in = gate_a[c]; ref_in = ref_a[c];
      end
      @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      #3 rst = 1'b1;
      #1;
      chk("abort_count",   32'(count),   32'd0);
      chk("abort_valid",   32'(valid),   32'd0);
      chk("abort_busy",    32'(busy),    32'd0);
      chk("abort_ovf",     32'(ovf),     32'd0);
      chk("abort_timeout", 32'(timeout), 32'd0);
      sig_in = 1'b0; gate_in = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("abort_idle_busy",  32'(busy),  32'd0);
      chk("abort_idle_valid", 32'(valid), 32'd0);
      idle_low(4);

      // Directed period: ref every 50 cycles, sig period 5000
      clr();
      for (int t = 25; t < LMAX; t++) ref_a[t] = ((t - 25) % 50) < 25;
      for (int t = 10; t < 2510; t++) sig_a[t] = 1'b1;
      for (int t = 5010; t < 5020; t++) sig_a[t] = 1'b1;
      model_period(e_cnt, e_ovf, e_vidx);
      run_meas(1'b1, e_cnt, e_ovf, 1'b0, e_vidx, "period100");

      // Saturation: 300 edges in window, then a clean 10-edge measurement
      clr();
      for (int t = 5; t < 605; t++) gate_a[t] = 1'b1;
      for (int t = 6; t < 606; t++) sig_a[t] = (t % 2) == 0;
      model_freq(e_cnt, e_ovf, e_vidx);
      run_meas(1'b0, e_cnt, e_ovf, 1'b0, e_vidx, "sat300");
      clr();
      for (int t = 5; t < 205; t++) gate_a[t] = 1'b1;
      for (int t = 10; t < 200; t++) sig_a[t] = ((t - 10) % 20) < 10;
      model_freq(e_cnt, e_ovf, e_vidx);
      run_meas(1'b0, e_cnt, e_ovf, 1'b0, e_vidx, "after_sat10");

      // Coincident edges: sig rises with gate rise (counted) and gate fall (not)
      clr();
      for (int t = 10; t < 60; t++) gate_a[t] = 1'b1;
      for (int t = 10; t < 70; t++) sig_a[t] = ((t - 10) % 10) < 5;
      model_freq(e_cnt, e_ovf, e_vidx);
      run_meas(1'b0, e_cnt, e_ovf, 1'b0, e_vidx, "coincident");

      // Random frequency and period measurements
      for (int i = 0; i < 6; i++) begin
         int g0 = int'($urandom_range(2, 10));
         int g1 = g0 + int'($urandom_range(1, 400));
         clr();
         for (int t = g0; t < g1; t++) gate_a[t] = 1'b1;
         rand_fill(0, 0, g1 + 10);
         rand_fill(2, 0, g1 + 10);
         model_freq(e_cnt, e_ovf, e_vidx);
         run_meas(1'b0, e_cnt, e_ovf, 1'b0, e_vidx, $sformatf("rfreq%0d", i));
      end
      for (int i = 0; i < 6; i++) begin
         int s1 = int'($urandom_range(2, 10));
         int s2 = s1 + int'($urandom_range(3, 600));
         int h  = int'($urandom_range(1, s2 - s1 - 1));
         clr();
         for (int t = s1; t < s1 + h; t++) sig_a[t] = 1'b1;
         for (int t = s2; t < s2 + 20; t++) sig_a[t] = 1'b1;
         rand_fill(2, 0, s2 + 20);
         model_period(e_cnt, e_ovf, e_vidx);
         run_meas(1'b1, e_cnt, e_ovf, 1'b0, e_vidx, $sformatf("rper%0d", i));
      end

      // Period mode with static sig: gate rises every 20 cycles
      clr();
      for (int t = 5; t < 400; t++) gate_a[t] = ((t - 5) % 20) < 10;
      third = 45;
`ifdef MEAS_TIMEOUT_EN
      run_meas(1'b1, SAT, 1'b0, 1'b1, third + 3, "timeout");
`else
      begin
         int vc = 0;
         @(posedge clk); #1;
         start = 1'b1; measure_mode = 1'b1;
         for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            sig_in = sig_a[c]; gate_in = gate_a[c]; ref_in = ref_a[c];
            @(negedge clk);
            if (valid) vc++;
         end
         chk("no_timeout_busy",  32'(busy), 32'd1);
         chk("no_timeout_valid", 32'(vc),   32'd0);
         #3 rst = 1'b1;
         @(negedge clk); rst = 1'b0;
         idle_low(4);
      end
`endif

      // A normal measurement completes after the timeout/abort scenario
      clr();
      for (int t = 4; t < 150; t++) gate_a[t] = 1'b1;
      rand_fill(0, 0, 160);
      model_freq(e_cnt, e_ovf, e_vidx);
      run_meas(1'b0, e_cnt, e_ovf, 1'b0, e_vidx, "final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
